// File: rtl/vram_painter.sv
// Drawing engine between the touch controller and the VRAM write port: sweeps
// the whole frame to the background colour, then stamps a square pen brush per touch.
module vram_painter #(
   parameter int          DISPLAY_WIDTH  = 240,
   parameter int          DISPLAY_HEIGHT = 320,
   parameter int          VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
   parameter int          BRUSH          = 3,
   parameter logic [15:0] BG_COLOR       = 16'hFFFF,
   localparam int         AW             = $clog2(VRAM_L)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          touch_valid,
   input  logic [8:0]    touch_x,
   input  logic [8:0]    touch_y,
   input  logic [15:0]   pen_color,
   output logic          vram_wr_ena,
   output logic [AW-1:0] vram_wr_addr,
   output logic [15:0]   vram_wr_data,
   output logic          clearing,
   output logic          busy
);

   localparam int                 R         = (BRUSH - 1) / 2;
   localparam int                 AW1       = AW + 1;
   localparam logic signed [3:0]  R_S       = 4'(R);
   localparam logic signed [10:0] W_S       = 11'(DISPLAY_WIDTH);
   localparam logic signed [10:0] H_S       = 11'(DISPLAY_HEIGHT);
   localparam logic [8:0]         W9        = 9'(DISPLAY_WIDTH);
   localparam logic [8:0]         H9        = 9'(DISPLAY_HEIGHT);
   localparam logic [AW-1:0]      LAST_ADDR = AW'(VRAM_L - 1);

   typedef enum logic [1:0] {
      S_CLEARING,
      S_IDLE,
      S_PAINT
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
   logic [8:0]          px_q, px_d, py_q, py_d;
   logic [8:0]          last_x_q, last_x_d, last_y_q, last_y_d;
   logic                last_ok_q, last_ok_d;
   logic [15:0]         color_q, color_d;
   logic signed [3:0]   dx_q, dx_d, dy_q, dy_d;
   logic                wr_ena_q, wr_ena_d;
   logic [AW-1:0]       wr_addr_q, wr_addr_d;
   logic [15:0]         wr_data_q, wr_data_d;
   logic                clearing_q, clearing_d;
   logic                busy_q, busy_d;

   logic signed [10:0]  sx, sy;
   logic [AW1-1:0]      ux, uy, slot_addr;
   logic                in_bounds;
   logic                slot_last;
   logic                touch_ok;

   // Current brush slot pixel, signed so that left/top clipping is a sign test.
   always_comb begin
      sx = $signed({2'b00, px_q}) + 11'(dx_q);
      sy = $signed({2'b00, py_q}) + 11'(dy_q);
      ux = AW1'(sx);
      uy = AW1'(sy);
      if (DISPLAY_WIDTH == 240) begin
         slot_addr = (uy << 8) - (uy << 4) + ux;
      end else begin
         slot_addr = uy * AW1'(DISPLAY_WIDTH) + ux;
      end
      in_bounds = (sx >= 11'sd0) && (sx < W_S) && (sy >= 11'sd0) && (sy < H_S)
                  && !slot_addr[AW];
      slot_last = (dx_q == R_S) && (dy_q == R_S);
      touch_ok  = touch_valid && (touch_x < W9) && (touch_y < H9)
                  && (!last_ok_q || (touch_x != last_x_q) || (touch_y != last_y_q));
   end

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      px_d       = px_q;
      py_d       = py_q;
      last_x_d   = last_x_q;
      last_y_d   = last_y_q;
      last_ok_d  = last_ok_q;
      color_d    = color_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      wr_ena_d   = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      clearing_d = (state_q == S_CLEARING);
      busy_d     = (state_q != S_IDLE);

      case (state_q)
         S_CLEARING: begin
            wr_ena_d  = 1'b1;
            wr_addr_d = clr_cnt_q;
            wr_data_d = BG_COLOR;
            if (clr_cnt_q == LAST_ADDR) begin
               clr_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end

         S_IDLE: begin
            // A lifted pen forgets the last point so a re-tap repaints it.
            if (!touch_valid) begin
               last_ok_d = 1'b0;
            end
            if (clear) begin
               state_d   = S_CLEARING;
               clr_cnt_d = '0;
            end else if (touch_ok) begin
               px_d      = touch_x;
               py_d      = touch_y;
               color_d   = pen_color;
               last_x_d  = touch_x;
               last_y_d  = touch_y;
               last_ok_d = 1'b1;
               dx_d      = -R_S;
               dy_d      = -R_S;
               state_d   = S_PAINT;
            end
         end

         S_PAINT: begin
            if (in_bounds) begin
               wr_ena_d  = 1'b1;
               wr_addr_d = slot_addr[AW-1:0];
               wr_data_d = color_q;
            end
            if (dx_q == R_S) begin
               dx_d = -R_S;
               dy_d = dy_q + 4'sd1;
            end else begin
               dx_d = dx_q + 4'sd1;
            end
            if (slot_last) begin
               state_d = S_IDLE;
            end
            // The slot registered this cycle still goes out; the rest are dropped.
            if (clear) begin
               state_d   = S_CLEARING;
               clr_cnt_d = '0;
            end
         end

         default: begin
            state_d   = S_CLEARING;
            clr_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_CLEARING;
         clr_cnt_q  <= '0;
         px_q       <= '0;
         py_q       <= '0;
         last_x_q   <= '0;
         last_y_q   <= '0;
         last_ok_q  <= 1'b0;
         color_q    <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         wr_ena_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         clearing_q <= 1'b1;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         px_q       <= px_d;
         py_q       <= py_d;
         last_x_q   <= last_x_d;
         last_y_q   <= last_y_d;
         last_ok_q  <= last_ok_d;
         color_q    <= color_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         wr_ena_q   <= wr_ena_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         clearing_q <= clearing_d;
         busy_q     <= busy_d;
      end
   end

   assign vram_wr_ena  = wr_ena_q;
   assign vram_wr_addr = wr_addr_q;
   assign vram_wr_data = wr_data_q;
   assign clearing     = clearing_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vram_painter.sv
// Self-checking bench for vram_painter: a transaction-level model predicts every
// VRAM write (edge, address, data) from the touch stream and compares with the DUT.
module tb_vram_painter;

   localparam int W  = 240;
   localparam int H  = 320;
   localparam int VL = W * H;
   localparam int BR = 3;
   localparam int R  = (BR - 1) / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        touch_valid = 1'b0;
   logic [8:0]  touch_x = '0;
   logic [8:0]  touch_y = '0;
   logic [15:0] pen_color = '0;
   logic        vram_wr_ena;
   logic [16:0] vram_wr_addr;
   logic [15:0] vram_wr_data;
   logic        clearing;
   logic        busy;

   vram_painter dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .touch_valid  (touch_valid),
      .touch_x      (touch_x),
      .touch_y      (touch_y),
      .pen_color    (pen_color),
      .vram_wr_ena  (vram_wr_ena),
      .vram_wr_addr (vram_wr_addr),
      .vram_wr_data (vram_wr_data),
      .clearing     (clearing),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Edge counter: a write registered at edge n is logged with e = n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int e;
      int addr;
      int data;
   } wr_t;

   wr_t wq[$];
   wr_t expq[$];
   bit  log_en = 1'b0;

   int checks = 0;
   int failures = 0;

   always @(negedge clk) begin
      if (log_en && vram_wr_ena === 1'b1)
         wq.push_back('{e: cyc, addr: int'(vram_wr_addr), data: int'(vram_wr_data)});
   end

   // Reference model state: first edge at which the painter is idle, and last accepted point.
   int m_free = 0;
   bit m_last_ok = 1'b0;
   int m_lx = 0;
   int m_ly = 0;

   function automatic void model_step(input int e, input bit v, input int x, input int y, input int c);
      int slot;
      if (e < m_free) return;
      if (!v) begin
         m_last_ok = 1'b0;
         return;
      end
      if (x >= W || y >= H) return;
      if (m_last_ok && x == m_lx && y == m_ly) return;
      m_last_ok = 1'b1;
      m_lx = x;
      m_ly = y;
      m_free = e + BR * BR + 1;
      slot = 0;
      for (int dy = -R; dy <= R; dy++) begin
         for (int dx = -R; dx <= R; dx++) begin
            if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
               expq.push_back('{e: e + 1 + slot, addr: (y + dy) * W + (x + dx), data: c});
            slot++;
         end
      end
   endfunction

   task automatic drive_cycle(input bit v, input int x, input int y, input int c);
      touch_valid = v;
      touch_x     = 9'(x);
      touch_y     = 9'(y);
      pen_color   = 16'(c);
      model_step(cyc + 1, v, x, y, c);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(1'b0, 0, 0, 0);
   endtask

   task automatic test_reset();
      int bad = 0;
      int bad_i = -1;
      int bad_a = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (vram_wr_ena !== 1'b0) begin failures++; $display("[TB] FAIL reset_ena got=%0b want=0", vram_wr_ena); end
      checks++; if (vram_wr_addr !== 17'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0d want=0", vram_wr_addr); end
      checks++; if (vram_wr_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0000", vram_wr_data); end
      checks++; if (clearing !== 1'b1) begin failures++; $display("[TB] FAIL reset_clearing got=%0b want=1", clearing); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy got=%0b want=1", busy); end
      rst = 1'b1;
      for (int i = 0; i < VL; i++) begin
         @(negedge clk);
         if (vram_wr_ena !== 1'b1 || vram_wr_addr !== 17'(i) || vram_wr_data !== 16'hFFFF
             || clearing !== 1'b1 || busy !== 1'b1) begin
            if (bad == 0) begin bad_i = i; bad_a = int'(vram_wr_addr); end
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL reset_sweep bad_slots=%0d first_slot=%0d got_addr=%0d want_addr=%0d", bad, bad_i, bad_a, bad_i);
      end
      @(negedge clk);
      checks++; if (vram_wr_ena !== 1'b0) begin failures++; $display("[TB] FAIL sweep_end_ena got=%0b want=0", vram_wr_ena); end
      checks++; if (clearing !== 1'b0) begin failures++; $display("[TB] FAIL sweep_end_clearing got=%0b want=0", clearing); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL sweep_end_busy got=%0b want=0", busy); end
      m_free = 0;
      m_last_ok = 1'b0;
      log_en = 1'b1;
   endtask

   task automatic test_centre();
      int exp_addr[9] = '{11859, 11860, 11861, 12099, 12100, 12101, 12339, 12340, 12341};
      wq.delete(); expq.delete();
      idle(1);
      drive_cycle(1'b1, 100, 50, 16'hF800);
      idle(12);
      checks++;
      if (wq.size() != expq.size()) begin failures++; $display("[TB] FAIL centre_count got=%0d want=%0d", wq.size(), expq.size()); end
      for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
         checks++;
         if (wq[i].e !== expq[i].e || wq[i].addr !== expq[i].addr || wq[i].data !== expq[i].data) begin
            failures++;
            $display("[TB] FAIL centre_write[%0d] got e=%0d a=%0d d=%h want e=%0d a=%0d d=%h", i, wq[i].e, wq[i].addr, wq[i].data, expq[i].e, expq[i].addr, expq[i].data);
         end
      end
      for (int i = 0; i < 9 && i < wq.size(); i++) begin
         checks++;
         if (wq[i].addr !== exp_addr[i] || wq[i].data !== 32'hF800) begin
            failures++;
            $display("[TB] FAIL centre_addr[%0d] got a=%0d d=%h want a=%0d d=f800", i, wq[i].addr, wq[i].data, exp_addr[i]);
         end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL centre_idle busy got=%0b want=0", busy); end
   endtask

   task automatic test_corners();
      int exp_addr[8] = '{0, 1, 240, 241, 76558, 76559, 76798, 76799};
      wq.delete(); expq.delete();
      idle(1);
      drive_cycle(1'b1, 0, 0, 16'h1234);
      idle(11);
      drive_cycle(1'b1, 239, 319, 16'hABCD);
      idle(12);
      checks++;
      if (wq.size() != 8) begin failures++; $display("[TB] FAIL corner_count got=%0d want=8", wq.size()); end
      for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
         checks++;
         if (wq[i].e !== expq[i].e || wq[i].addr !== expq[i].addr || wq[i].data !== expq[i].data) begin
            failures++;
            $display("[TB] FAIL corner_write[%0d] got e=%0d a=%0d d=%h want e=%0d a=%0d d=%h", i, wq[i].e, wq[i].addr, wq[i].data, expq[i].e, expq[i].addr, expq[i].data);
         end
      end
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         checks++;
         if (wq[i].addr !== exp_addr[i]) begin
            failures++;
            $display("[TB] FAIL corner_addr[%0d] got=%0d want=%0d", i, wq[i].addr, exp_addr[i]);
         end
      end
   endtask

   task automatic test_dedupe();
      wq.delete(); expq.delete();
      idle(1);
      repeat (50) drive_cycle(1'b1, 10, 10, 16'h0F0F);
      drive_cycle(1'b0, 10, 10, 16'h0F0F);
      repeat (12) drive_cycle(1'b1, 10, 10, 16'h0F0F);
      idle(2);
      checks++;
      if (wq.size() != 18) begin failures++; $display("[TB] FAIL dedupe_count got=%0d want=18", wq.size()); end
      for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
         checks++;
         if (wq[i].e !== expq[i].e || wq[i].addr !== expq[i].addr || wq[i].data !== expq[i].data) begin
            failures++;
            $display("[TB] FAIL dedupe_write[%0d] got e=%0d a=%0d want e=%0d a=%0d", i, wq[i].e, wq[i].addr, expq[i].e, expq[i].addr);
         end
      end
   endtask

   task automatic test_range_reject();
      wq.delete(); expq.delete();
      idle(1);
      for (int i = 0; i < 6; i++) begin
         if (i < 3) drive_cycle(1'b1, 240, 5, 16'h5555);
         else       drive_cycle(1'b1, 5, 320, 16'h5555);
         checks++;
         if (busy !== 1'b0) begin failures++; $display("[TB] FAIL range_busy[%0d] got=%0b want=0", i, busy); end
      end
      idle(3);
      checks++;
      if (wq.size() != expq.size()) begin failures++; $display("[TB] FAIL range_writes got=%0d want=%0d", wq.size(), expq.size()); end
   endtask

   task automatic test_back_to_back();
      wq.delete(); expq.delete();
      idle(1);
      drive_cycle(1'b1, 50, 60, 16'h00AA);
      repeat (10) drive_cycle(1'b1, 70, 80, 16'h00BB);
      idle(12);
      checks++;
      if (wq.size() != expq.size()) begin failures++; $display("[TB] FAIL b2b_count got=%0d want=%0d", wq.size(), expq.size()); end
      for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
         checks++;
         if (wq[i].e !== expq[i].e || wq[i].addr !== expq[i].addr || wq[i].data !== expq[i].data) begin
            failures++;
            $display("[TB] FAIL b2b_write[%0d] got e=%0d a=%0d d=%h want e=%0d a=%0d d=%h", i, wq[i].e, wq[i].addr, wq[i].data, expq[i].e, expq[i].addr, expq[i].data);
         end
      end
   endtask

   task automatic test_random();
      int x = 5;
      int y = 5;
      int mode;
      bit v;
      wq.delete(); expq.delete();
      idle(1);
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 9) < 7);
         mode = $urandom_range(0, 3);
         if (mode == 1) begin
            x = $urandom_range(0, 259);
            y = $urandom_range(0, 339);
         end else if (mode == 2) begin
            x = ($urandom_range(0, 1) == 0) ? 0 : 239 + $urandom_range(0, 1);
            y = ($urandom_range(0, 1) == 0) ? 0 : 319 + $urandom_range(0, 1);
         end
         drive_cycle(v, x, y, int'($urandom_range(0, 65535)));
      end
      idle(12);
      checks++;
      if (wq.size() != expq.size()) begin failures++; $display("[TB] FAIL random_count got=%0d want=%0d", wq.size(), expq.size()); end
      for (int i = 0; i < wq.size() && i < expq.size(); i++) begin
         checks++;
         if (wq[i].e !== expq[i].e || wq[i].addr !== expq[i].addr || wq[i].data !== expq[i].data) begin
            failures++;
            $display("[TB] FAIL random_write[%0d] got e=%0d a=%0d d=%h want e=%0d a=%0d d=%h", i, wq[i].e, wq[i].addr, wq[i].data, expq[i].e, expq[i].addr, expq[i].data);
         end
      end
   endtask

   task automatic test_clear_mid_paint();
      int e0, k, cyc_end;
      int n_paint = 0;
      int sweep_n = 0;
      int bad = 0;
      int bad_i = -1;
      wq.delete(); expq.delete();
      idle(1);
      e0 = cyc + 1;
      drive_cycle(1'b1, 120, 160, 16'h07E0);
      idle(3);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         touch_valid = (i >= 200 && i < 210);
         touch_x     = 9'd30;
         touch_y     = 9'd40;
         pen_color   = 16'h001F;
         clear       = (i == 600);
         @(negedge clk);
      end
      touch_valid = 1'b0;
      clear = 1'b0;
      #1 cyc_end = cyc;
      foreach (wq[i]) begin
         if (wq[i].e <= e0 + 4) begin
            k = wq[i].e - (e0 + 1);
            checks++;
            if (k < 0 || k >= expq.size() || wq[i].addr !== expq[k].addr || wq[i].data !== expq[k].data) begin
               failures++;
               $display("[TB] FAIL abort_paint_write e=%0d got a=%0d d=%h", wq[i].e, wq[i].addr, wq[i].data);
            end
            n_paint++;
         end else begin
            if (wq[i].e !== e0 + 5 + sweep_n || wq[i].addr !== sweep_n || wq[i].data !== 32'hFFFF) begin
               if (bad == 0) bad_i = i;
               bad++;
            end
            sweep_n++;
         end
      end
      checks++;
      if (n_paint < 3 || n_paint > 4) begin failures++; $display("[TB] FAIL abort_paint_count got=%0d want=3..4", n_paint); end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL clear_sweep bad=%0d first got e=%0d a=%0d d=%h want e=%0d a=%0d d=ffff", bad, wq[bad_i].e, wq[bad_i].addr, wq[bad_i].data, e0 + 5 + (bad_i - n_paint), bad_i - n_paint);
      end
      checks++;
      if (sweep_n !== cyc_end - (e0 + 5) + 1) begin failures++; $display("[TB] FAIL clear_sweep_len got=%0d want=%0d", sweep_n, cyc_end - (e0 + 5) + 1); end
      checks++;
      if (clearing !== 1'b1) begin failures++; $display("[TB] FAIL clear_clearing got=%0b want=1", clearing); end
   endtask

   task automatic test_async_reset();
      #2 rst = 1'b0;
      #1;
      checks++; if (vram_wr_ena !== 1'b0) begin failures++; $display("[TB] FAIL async_ena got=%0b want=0", vram_wr_ena); end
      checks++; if (vram_wr_addr !== 17'd0) begin failures++; $display("[TB] FAIL async_addr got=%0d want=0", vram_wr_addr); end
      checks++; if (vram_wr_data !== 16'h0) begin failures++; $display("[TB] FAIL async_data got=%h want=0000", vram_wr_data); end
      checks++; if (clearing !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL async_flags got=%0b%0b want=11", clearing, busy); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (vram_wr_ena !== 1'b1 || vram_wr_addr !== 17'd0) begin failures++; $display("[TB] FAIL restart_first got ena=%0b a=%0d want ena=1 a=0", vram_wr_ena, vram_wr_addr); end
      @(negedge clk);
      checks++;
      if (vram_wr_ena !== 1'b1 || vram_wr_addr !== 17'd1) begin failures++; $display("[TB] FAIL restart_second got ena=%0b a=%0d want ena=1 a=1", vram_wr_ena, vram_wr_addr); end
   endtask

   initial begin
      #(95_000 * 10);
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_centre();
      test_corners();
      test_dedupe();
      test_range_reject();
      test_back_to_back();
      test_random();
      test_clear_mid_paint();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
